// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
//   skid_state_t   : occupancy of the stage (EMPTY / ONE / TWO held entries)
//   PIPE_PAYLOAD_W : default payload width in bits
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int PIPE_PAYLOAD_W = 223;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with a load enable and an asynchronous active-low clear.
// It is used twice in the skid stage, once for the main entry and once for the skid entry.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear, drives q to 0
//   en    : load d at the next rising edge
//   d     : LENGTH-bit input payload
//   q     : LENGTH-bit registered payload
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int LENGTH = PIPE_PAYLOAD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LENGTH-1:0] d,
    output logic [LENGTH-1:0] q
);

    logic [LENGTH-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a valid/ready handshake on both sides.
// The stage holds up to two entries (main + skid). Because it has the extra skid slot,
// in_ready depends only on registered state, and upstream can still stream one word
// per cycle when the consumer applies backpressure late.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset (state EMPTY, data cleared)
//   flush     : drop every held entry at the next edge; this takes priority over all other events
//   in_valid  : producer presents in_data
//   in_ready  : stage can accept (state != TWO)
//   in_data   : producer payload
//   out_valid : out_data holds a valid entry (state != EMPTY)
//   out_ready : consumer takes out_data this cycle
//   out_data  : oldest held payload (main register)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int LENGTH = PIPE_PAYLOAD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data
);

    skid_state_t       state_q;
    skid_state_t       state_d;
    logic [LENGTH-1:0] main_q;
    logic [LENGTH-1:0] main_d;
    logic [LENGTH-1:0] skid_q;
    logic              main_en;
    logic              skid_en;
    logic              accept;
    logic              drain;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. During a flush, any concurrent drain is treated as taken and any
    // concurrent accept is dropped. Both cases come out right because the stage goes to EMPTY.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !drain)      state_d = TWO;
                    else if (!accept && drain) state_d = EMPTY;
                end
                TWO:     if (drain) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output and datapath decode.
    // main loads new data when it will be empty after this edge or is being drained while a new
    // word arrives. The word comes from the skid slot when the stage leaves TWO, so order is kept.
    // skid loads only when a second word arrives and the consumer does not drain.
    // A flush leaves both data registers unchanged.
    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        if (!flush) begin
            case (state_q)
                EMPTY: main_en = accept;
                ONE: begin
                    main_en = accept && drain;
                    skid_en = accept && !drain;
                end
                TWO: begin
                    main_en = drain;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    pipe_data_reg #(.LENGTH(LENGTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.LENGTH(LENGTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// The reference model is an ordered queue that holds at most two words.
// The model is ready when it holds fewer than two words and valid when it is not empty.
// Its head is the expected out_data.
module tb_pipe_stage_skid;

    localparam int L = 223;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [L-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [L-1:0] out_data;

    logic [L-1:0] mq[$];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.LENGTH(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk_data(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // Compare the DUT outputs with the queue model.
    task automatic compare_model();
        chk_bit("model_out_valid", out_valid, mq.size() != 0);
        chk_bit("model_in_ready", in_ready, mq.size() < 2);
        if (mq.size() != 0) chk_data("model_out_data", out_data, mq[0]);
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model at the edge.
    task automatic cycle(input logic v, input logic [L-1:0] d, input logic r, input logic f);
        logic acc;
        logic drn;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        compare_model();
        acc = v && (mq.size() < 2) && reset;
        drn = r && (mq.size() != 0) && reset;
        @(posedge clk);
        if (!reset || f) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        #1;
    endtask

    function automatic logic [L-1:0] rnd_payload();
        logic [L-1:0] p = '0;
        for (int i = 0; i < L; i += 32) p = (p << 32) | L'($urandom);
        return p;
    endfunction

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state. Accepts offered during reset must be ignored.
        cycle(1'b1, L'(32'h55), 1'b1, 1'b0);
        cycle(1'b1, L'(32'h66), 1'b0, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_data("rst_out_data", out_data, '0);
        #2 reset = 1'b1;

        // Stream with out_ready held high.
        cycle(1'b1, L'(32'h1), 1'b1, 1'b0);
        chk_data("stream_d1", out_data, L'(32'h1));
        cycle(1'b1, L'(32'h2), 1'b1, 1'b0);
        chk_data("stream_d2", out_data, L'(32'h2));
        cycle(1'b1, L'(32'h3), 1'b1, 1'b0);
        chk_data("stream_d3", out_data, L'(32'h3));
        chk_bit("stream_ready", in_ready, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: 0xA and 0xB are absorbed, and 0xC is held off.
        cycle(1'b1, L'(32'hA), 1'b0, 1'b0);
        cycle(1'b1, L'(32'hB), 1'b0, 1'b0);
        chk_bit("bp_ready_low", in_ready, 1'b0);
        chk_data("bp_head", out_data, L'(32'hA));
        cycle(1'b1, L'(32'hC), 1'b0, 1'b0);
        cycle(1'b1, L'(32'hC), 1'b1, 1'b0);
        chk_data("bp_second", out_data, L'(32'hB));
        chk_bit("bp_ready_back", in_ready, 1'b1);
        cycle(1'b1, L'(32'hC), 1'b1, 1'b0);
        chk_data("bp_third", out_data, L'(32'hC));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous accept and drain in ONE.
        cycle(1'b1, L'(32'h5), 1'b0, 1'b0);
        chk_data("sim_main5", out_data, L'(32'h5));
        cycle(1'b1, L'(32'h6), 1'b1, 1'b0);
        chk_data("sim_main6", out_data, L'(32'h6));
        chk_bit("sim_valid", out_valid, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in TWO with a concurrent in_valid carrying 0x7.
        cycle(1'b1, L'(32'h10), 1'b0, 1'b0);
        cycle(1'b1, L'(32'h11), 1'b0, 1'b0);
        cycle(1'b1, L'(32'h7), 1'b1, 1'b1);
        chk_bit("flush_valid", out_valid, 1'b0);
        chk_bit("flush_ready", in_ready, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset asserted between edges while the stage is in TWO.
        cycle(1'b1, L'(32'h20), 1'b0, 1'b0);
        cycle(1'b1, L'(32'h21), 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        mq.delete();
        chk_bit("arst_valid", out_valid, 1'b0);
        chk_data("arst_data", out_data, '0);
        chk_bit("arst_ready", in_ready, 1'b1);
        cycle(1'b1, L'(32'h99), 1'b1, 1'b0);
        #2 reset = 1'b1;
        cycle(1'b1, L'(32'h9), 1'b0, 1'b0);
        chk_data("arst_after", out_data, L'(32'h9));
        chk_bit("arst_after_v", out_valid, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Random valid/ready/flush traffic with random payloads.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), rnd_payload(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
